// File: rtl/adc_framer_pkg.sv
// rtl/adc_framer_pkg.sv - shared FSM encoding, lane width default and sign extension for adc_axis_framer
package adc_framer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } framer_state_t;

    localparam int SAMP_W_DEFAULT = 16;

    // Sign-extend the low 'width' bits of a zero-extended raw value to 32 bits.
    function automatic logic [31:0] sign_ext(input logic [31:0] raw, input int width);
        logic [31:0] w_msb;
        w_msb = 32'd1 << (width - 1);
        return (raw ^ w_msb) - w_msb;
    endfunction

endpackage

// File: rtl/axis_fifo_sync.sv
// rtl/axis_fifo_sync.sv - single-clock first-word-fall-through FIFO with registered storage
module axis_fifo_sync #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    output logic         o_wr_ack,
    output logic [W-1:0] o_rd_data,
    output logic         o_rd_valid,
    input  logic         i_rd_en
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    assign w_full     = (r_count == (AW + 1)'(DEPTH));
    assign o_rd_valid = (r_count != '0);
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign w_rd       = i_rd_en && o_rd_valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wr       = i_wr_en && (!w_full || w_rd);
    assign o_wr_ack   = w_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/adc_axis_framer.sv
// rtl/adc_axis_framer.sv - multi-channel ADC capture framer to AXI4-Stream
// Optional ramp test pattern enabled by defining ADC_FRAMER_TESTPAT_EN.
module adc_axis_framer
    import adc_framer_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int ADC_W      = 14,
    parameter int SAMP_W     = SAMP_W_DEFAULT,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    input  logic                    adc_clock,
    input  logic                    adc_rst_n,
    input  logic [NCH*ADC_W-1:0]    adc_dat_i,
    input  logic                    adc_valid_i,
    input  logic                    arm_i,
    input  logic                    trig_i,
    input  logic                    abort_i,
    input  logic [LEN_W-1:0]        pkt_len_i,
    input  logic [LEN_W-1:0]        n_pkts_i,
    input  logic [7:0]              decim_i,
`ifdef ADC_FRAMER_TESTPAT_EN
    input  logic                    test_mode_i,
`endif
    output logic [NCH*SAMP_W-1:0]   m_axis_tdata,
    output logic [NCH*SAMP_W/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int TDATA_W = NCH * SAMP_W;

    framer_state_t      r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_npkts;
    logic [LEN_W-1:0]   r_beat;
    logic [LEN_W-1:0]   r_pkt;
    logic [7:0]         r_decim;
    logic [7:0]         r_dcnt;
    logic               r_abort;
    logic               r_done;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    logic [TDATA_W-1:0] w_lanes;
    logic [TDATA_W:0]   w_fifo_dout;
    logic               w_abort_now;
    logic               w_hold;
    logic               w_qual;
    logic               w_push_ack;
    logic               w_last_beat;
    logic               w_last_pkt;
    logic               w_pop;

    assign w_abort_now = r_abort || abort_i;
    // Aborting on a packet boundary: nothing more is taken, so no packet is left short.
    assign w_hold      = w_abort_now && (r_beat == '0);
    assign w_qual      = (r_state == S_RUN) && adc_valid_i && (r_dcnt == 8'd0) && !w_hold;
    assign w_last_beat = (r_beat == r_len - LEN_W'(1));
    assign w_last_pkt  = (r_npkts != '0) && (r_pkt == r_npkts - LEN_W'(1));
    assign w_pop       = m_axis_tvalid && m_axis_tready;

`ifdef ADC_FRAMER_TESTPAT_EN
    logic [15:0] r_ramp;

    always_comb begin
        w_lanes = '0;
        for (int k = 0; k < NCH; k++) begin
            w_lanes[k*SAMP_W +: SAMP_W] = test_mode_i ? SAMP_W'(r_ramp + 16'(k))
                : SAMP_W'(sign_ext(32'(adc_dat_i[k*ADC_W +: ADC_W]), ADC_W));
        end
    end

    always_ff @(posedge adc_clock or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_ramp <= '0;
        end else if ((r_state == S_IDLE) && arm_i) begin
            r_ramp <= '0;
        end else if (w_push_ack) begin
            r_ramp <= r_ramp + 16'd1;
        end
    end
`else
    always_comb begin
        w_lanes = '0;
        for (int k = 0; k < NCH; k++) begin
            w_lanes[k*SAMP_W +: SAMP_W] = SAMP_W'(sign_ext(32'(adc_dat_i[k*ADC_W +: ADC_W]), ADC_W));
        end
    end
`endif

    axis_fifo_sync #(
        .W     (TDATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (adc_clock),
        .rst_n      (adc_rst_n),
        .i_wr_en    (w_qual),
        .i_wr_data  ({w_last_beat, w_lanes}),
        .o_wr_ack   (w_push_ack),
        .o_rd_data  (w_fifo_dout),
        .o_rd_valid (m_axis_tvalid),
        .i_rd_en    (w_pop)
    );

    assign m_axis_tdata = w_fifo_dout[TDATA_W-1:0];
    assign m_axis_tlast = w_fifo_dout[TDATA_W];
    assign m_axis_tkeep = '1;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign overflow_o   = r_overflow;
    assign drop_cnt_o   = r_drop_cnt;

    always_ff @(posedge adc_clock or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_npkts    <= '0;
            r_beat     <= '0;
            r_pkt      <= '0;
            r_decim    <= '0;
            r_dcnt     <= '0;
            r_abort    <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == S_RUN) && adc_valid_i) begin
                r_dcnt <= (r_dcnt == r_decim) ? 8'd0 : r_dcnt + 8'd1;
            end
            if (w_qual && !w_push_ack) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
            // Beat/packet counters only follow accepted pushes, so drops never shorten a packet.
            if (w_push_ack) begin
                if (w_last_beat) begin
                    r_beat <= '0;
                    if (r_pkt != '1) begin
                        r_pkt <= r_pkt + LEN_W'(1);
                    end
                end else begin
                    r_beat <= r_beat + LEN_W'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (arm_i) begin
                        r_len      <= (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
                        r_npkts    <= n_pkts_i;
                        r_decim    <= decim_i;
                        r_dcnt     <= '0;
                        r_beat     <= '0;
                        r_pkt      <= '0;
                        r_abort    <= 1'b0;
                        r_overflow <= 1'b0;
                        r_drop_cnt <= '0;
                        r_state    <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (abort_i) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (trig_i) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        r_abort <= 1'b1;
                    end
                    if (w_hold) begin
                        r_state <= S_DRAIN;
                    end else if (w_push_ack && w_last_beat && (w_abort_now || w_last_pkt)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!m_axis_tvalid) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_axis_framer.sv
// tb/tb_adc_axis_framer.sv - randomized scoreboard bench for adc_axis_framer
module tb_adc_axis_framer;

    localparam int NCH   = 2;
    localparam int ADC_W = 14;
    localparam int SAMP_W = 16;
    localparam int DEPTH = 16;
    localparam int LEN_W = 16;
    localparam int TW    = NCH * SAMP_W;
    localparam int DW    = NCH * ADC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     adc_dat_i = '0;
    logic              adc_valid_i = 1'b0;
    logic              arm_i = 1'b0;
    logic              trig_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [LEN_W-1:0]  pkt_len_i = '0;
    logic [LEN_W-1:0]  n_pkts_i = '0;
    logic [7:0]        decim_i = '0;
    logic [TW-1:0]     m_axis_tdata;
    logic [TW/8-1:0]   m_axis_tkeep;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;
    logic [15:0]       drop_cnt_o;

    always #5 clk = ~clk;

    adc_axis_framer #(
        .NCH(NCH), .ADC_W(ADC_W), .SAMP_W(SAMP_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .adc_clock     (clk),
        .adc_rst_n     (rst_n),
        .adc_dat_i     (adc_dat_i),
        .adc_valid_i   (adc_valid_i),
        .arm_i         (arm_i),
        .trig_i        (trig_i),
        .abort_i       (abort_i),
        .pkt_len_i     (pkt_len_i),
        .n_pkts_i      (n_pkts_i),
        .decim_i       (decim_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    typedef struct {
        logic [TW-1:0] data;
        logic          last;
    } beat_t;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t mon_e;
    int    beats_seen = 0;
    int    done_seen = 0;
    int    done_base = 0;
    int    tr_mode = 0;  // 0: always ready, 1: random ready, 2: stalled
    logic          prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // Reference model state: counts of valid samples, accepted beats and drops.
    int m_len, m_limit, m_decim, m_idx, m_taken, m_drops;
    bit m_abort;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] pack(input logic [DW-1:0] d);
        logic [TW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            v = int'(d[k*ADC_W +: ADC_W]);
            if (v >= (1 << (ADC_W - 1))) v = v - (1 << ADC_W);
            r[k*SAMP_W +: SAMP_W] = SAMP_W'(v);
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_dat();
        logic [31:0] r;
        r = $urandom;
        return r[DW-1:0];
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        m_axis_tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        if (done_o) done_seen++;
        if (m_axis_tvalid && prev_stall) begin
            check("hold_data", 64'(m_axis_tdata), 64'(prev_data));
            check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got data %0h last %0b, none expected", m_axis_tdata, m_axis_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", 64'(m_axis_tdata), 64'(mon_e.data));
                check("beat_last", 64'(m_axis_tlast), 64'(mon_e.last));
            end
        end
    end

    task automatic arm_cfg(input int len, input int npkts, input int dec);
        pkt_len_i = LEN_W'(len);
        n_pkts_i  = LEN_W'(npkts);
        decim_i   = 8'(dec);
        arm_i     = 1'b1;
        @(posedge clk);
        #1;
        arm_i     = 1'b0;
        pkt_len_i = LEN_W'($urandom);
        n_pkts_i  = LEN_W'($urandom);
        decim_i   = 8'($urandom);
        m_len   = (len == 0) ? 1 : len;
        m_limit = (npkts == 0) ? 32'h7fffffff : m_len * npkts;
        m_decim = dec;
        m_idx   = 0;
        m_taken = 0;
        m_drops = 0;
        m_abort = 0;
        beats_seen = 0;
        done_base  = done_seen;
        check("armed_busy", 64'(busy_o), 64'd1);
        check("arm_clears_overflow", 64'(overflow_o), 64'd0);
        check("arm_clears_drops", 64'(drop_cnt_o), 64'd0);
    endtask

    task automatic start_capture(input int len, input int npkts, input int dec);
        arm_cfg(len, npkts, dec);
        trig_i = 1'b1;
        @(posedge clk);
        #1;
        trig_i = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit ab);
        beat_t e;
        int ceil_len;
        adc_valid_i = v;
        adc_dat_i   = d;
        abort_i     = ab;
        if (ab && !m_abort) begin
            m_abort  = 1;
            ceil_len = ((m_taken + m_len - 1) / m_len) * m_len;
            if (ceil_len < m_limit) m_limit = ceil_len;
        end
        if (v) begin
            if ((m_idx % (m_decim + 1)) == 0 && m_taken < m_limit) begin
                if (tr_mode == 2 && m_taken >= DEPTH) begin
                    m_drops++;
                end else begin
                    e.data = pack(d);
                    e.last = ((m_taken % m_len) == m_len - 1);
                    exp_q.push_back(e);
                    m_taken++;
                end
            end
            m_idx++;
        end
        @(posedge clk);
        #1;
        adc_valid_i = 1'b0;
        abort_i     = 1'b0;
    endtask

    task automatic feed(input int pct, input int abort_after);
        int n;
        n = 0;
        while (m_taken < m_limit && n < 2000) begin
            drive($urandom_range(0, 99) < pct, rnd_dat(),
                  abort_after >= 0 && m_taken >= abort_after && !m_abort);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout: got %0d beats accepted, required %0d", m_taken, m_limit);
        end
        repeat (4) drive(1'b1, rnd_dat(), 1'b0);
    endtask

    task automatic finish_capture(input string name);
        int n;
        n = 0;
        while (done_seen == done_base && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, 64'(done_seen - done_base), 64'd1);
        check({name, "_busy_after"}, 64'(busy_o), 64'd0);
        check({name, "_tvalid_after"}, 64'(m_axis_tvalid), 64'd0);
        check({name, "_beats"}, 64'(beats_seen), 64'(m_taken));
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
        check("tkeep", 64'(m_axis_tkeep), 64'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Two packets of four, always ready.
        tr_mode = 0;
        start_capture(4, 2, 0);
        feed(100, -1);
        finish_capture("basic");

        // Decimate by 3 with a ramp on both channels and -1 on channel 0 first.
        start_capture(4, 1, 2);
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, {14'(i), (i == 0) ? 14'h3FFF : 14'(i)}, 1'b0);
        end
        finish_capture("decim");

        // Stalled sink: 16 buffered, 4 dropped, then release.
        tr_mode = 2;
        start_capture(4, 5, 0);
        repeat (20) drive(1'b1, rnd_dat(), 1'b0);
        check("ovf_flag", 64'(overflow_o), 64'd1);
        check("ovf_drops", 64'(drop_cnt_o), 64'(m_drops));
        tr_mode = 0;
        repeat (30) drive(1'b0, rnd_dat(), 1'b0);
        feed(100, -1);
        finish_capture("overflow");
        check("ovf_drops_final", 64'(drop_cnt_o), 64'd4);

        // Continuous mode ended by abort mid-packet.
        start_capture(5, 0, 0);
        feed(100, 7);
        finish_capture("abort_run");
        check("abort_run_total", 64'(beats_seen), 64'd10);

        // Zero length means one beat per packet; random backpressure.
        tr_mode = 1;
        start_capture(0, 3, 1);
        feed(60, -1);
        finish_capture("len_zero");

        // Random small captures (never more than DEPTH beats, so no drops).
        for (int t = 0; t < 6; t++) begin
            int len, np, ab;
            len = $urandom_range(1, 4);
            np  = $urandom_range(1, 4);
            ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len * np - 1) : -1;
            tr_mode = $urandom_range(0, 1);
            start_capture(len, np, $urandom_range(0, 3));
            feed($urandom_range(30, 100), ab);
            finish_capture("random");
        end
        tr_mode = 0;

        // Abort in IDLE is ignored.
        done_base = done_seen;
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_abort_done", 64'(done_seen - done_base), 64'd0);
        check("idle_abort_busy", 64'(busy_o), 64'd0);

        // Abort while armed: no beats, one done pulse.
        arm_cfg(4, 1, 0);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("armed_abort_done", 64'(done_seen - done_base), 64'd1);
        check("armed_abort_beats", 64'(beats_seen), 64'd0);
        check("armed_abort_busy", 64'(busy_o), 64'd0);

        // Reset mid-run with buffered data.
        tr_mode = 2;
        start_capture(4, 0, 0);
        repeat (6) drive(1'b1, rnd_dat(), 1'b0);
        check("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tr_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_done", 64'(done_seen - done_base), 64'd0);
        check("post_rst_beats", 64'(beats_seen), 64'd0);
        check("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_axis_framer.md
Name: adc_axis_framer

Overview:
- Multi-channel ADC capture framer. Packs NCH parallel ADC sample streams into an AXI4-Stream master for the PS S2MM DMA path.
- Adds arm/trigger sequencing, a programmable packet length and packet count, decimation, a buffering FIFO and overflow accounting.
- Sits between the ADC input registers and the S2MM DMA slave. Runs entirely on the ADC clock domain.

Parameters:
- NCH, 2, number of ADC channels packed per beat (1..4).
- ADC_W, 14, raw ADC sample width.
- SAMP_W, 16, per-channel lane width in TDATA; ADC_W is sign-extended to this width.
- FIFO_DEPTH, 16, output buffer depth in beats (power of 2, ≥4).
- LEN_W, 16, width of the packet-length and packet-count fields.
- Derived: TDATA_W = NCH*SAMP_W, which must be a multiple of 8; KEEP_W = TDATA_W/8.

Ports:
- adc_clock  in  1  sole clock.
- adc_rst_n  in  1  reset; asynchronous assert, active-low.
- adc_dat_i  in  NCH*ADC_W  channel k occupies [k*ADC_W +: ADC_W], two's complement.
- adc_valid_i  in  1  sample strobe.
- arm_i  in  1  single-cycle pulse; starts a capture.
- trig_i  in  1  trigger; sampled only in ARMED.
- abort_i  in  1  single-cycle pulse; ends capture at the next packet boundary.
- pkt_len_i  in  LEN_W  beats per packet; 0 is treated as 1.
- n_pkts_i  in  LEN_W  packets per capture; 0 means continuous until abort.
- decim_i  in  8  keep 1 of every decim_i+1 valid samples.
- m_axis_tdata  out  TDATA_W  packed beat.
- m_axis_tkeep  out  KEEP_W  always all ones.
- m_axis_tlast  out  1  last beat of each packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on return to IDLE.
- overflow_o  out  1  sticky; set on a dropped sample.
- drop_cnt_o  out  16  dropped-sample count; saturates at 0xFFFF.

Behaviour:
- Reset values:
  - state IDLE; FIFO empty.
  - tvalid, tlast, busy_o, done_o, overflow_o all 0; tdata = 0; drop_cnt_o = 0.
  - All counters 0.
- Configuration capture: pkt_len_i, n_pkts_i and decim_i are latched on arm_i accepted in IDLE. Later changes have no effect until the next arm.
- Accepted arm_i also clears overflow_o, drop_cnt_o, the decimation counter and the beat/packet counters.
- FSM:
  - IDLE: arm_i → ARMED. abort_i and trig_i are ignored.
  - ARMED: trig_i → RUN, and the first qualifying sample is taken on the following cycle. abort_i → IDLE with a done_o pulse. arm_i is ignored.
  - RUN: each valid sample with decim counter == 0 is a qualifying sample.
    - If the FIFO is not full, the sample is pushed with tlast = (beat_in_pkt == len-1).
    - When the last beat of packet n_pkts is pushed, go to DRAIN.
  - DRAIN: wait for FIFO empty and the final beat handshaken → IDLE, with done_o high for exactly one cycle.
- Abort in RUN:
  - Latched.
  - If beat_in_pkt == 0, go to DRAIN the next cycle.
  - Otherwise keep capturing until the current packet's tlast is pushed, then go to DRAIN. No packet is ever truncated.
- Abort and arm in the same cycle: the abort applies per current state; arm is honoured only in IDLE.
- Decimation:
  - The counter advances on every adc_valid_i in RUN and wraps at decim_i.
  - decim_i = 0 means every valid sample qualifies.
- Overflow: a qualifying sample arriving while the FIFO is full is dropped.
  - overflow_o is set and drop_cnt_o increments.
  - Beat and packet counters do not advance, so packet sizes stay exact.
- Packing: lane k = sign-extend(adc_dat_i[k*ADC_W +: ADC_W]) into m_axis_tdata[k*SAMP_W +: SAMP_W].
- Latency: FIFO is first-word-fall-through with a registered output. A sample pushed at cycle N gives tvalid at N+1 at the earliest.
- AXIS handshake:
  - tdata and tlast are held stable while tvalid && !tready.
  - Pop happens on tvalid && tready.
  - Simultaneous push and pop while full is allowed: the pop frees the slot and the push succeeds.
- Counter wrap: in continuous mode the packet counter saturates. Only abort ends the capture.
- Reset mid-operation: FIFO contents are discarded, tvalid drops immediately (asynchronous), and no done_o pulse is generated.

Optional Feature:
- ADC_FRAMER_TESTPAT_EN
- With the macro defined:
  - Adds input test_mode_i (1 bit).
  - When test_mode_i is high, lane k carries a 16-bit ramp + k instead of ADC data.
  - The ramp is cleared on arm and increments per pushed beat.
  - Dropped samples do not advance the ramp, so a gap in the ramp reveals nothing; drops are visible only in drop_cnt_o.
- Without the macro: no test_mode_i port and no ramp logic. Lanes always carry ADC data.

Decomposition:
- Shared package adc_framer_pkg: FSM state encoding (IDLE, ARMED, RUN, DRAIN), SAMP_W default, and a sign-extension function.
- Sub-module axis_fifo_sync: single-clock FWFT FIFO of width TDATA_W+1 (data plus tlast), depth FIFO_DEPTH, with full/empty flags.

Test Plan:
- pkt_len=4, n_pkts=2, decim=0, tready=1, continuous ramp input → 8 beats; tlast on beats 4 and 8; done_o one pulse; busy_o low after.
- decim=2, samples 0..11 with ch0=ch1 → beats carry 0,3,6,9; ch0 value −1 (14'h3FFF) appears as 16'hFFFF.
- tready=0 throughout, FIFO_DEPTH=16, 20 qualifying samples → 16 buffered; overflow_o=1; drop_cnt_o=4; tlast positions unchanged once tready=1.
- n_pkts=0, pkt_len=5, abort_i after 7 pushed beats → 10 beats total; tlast on beats 5 and 10; then IDLE.
- Arm, no trigger, abort in ARMED → zero beats output; done_o pulses; assert adc_rst_n low mid-RUN → tvalid=0 and FIFO empty within the same cycle.
